// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the cache line-fill / writeback controller.
package mem_bus_pkg;

    typedef enum logic [1:0] {IDLE, BEAT, RESP, GAP} state_t;

    localparam int MEM_BEATS  = 4;
    localparam int MEM_WORD_W = 32;
    localparam int MEM_LINE_W = 128;

    // Byte offset of a beat within its line; the line base supplies the upper bits.
    function automatic logic [3:0] beat_offset(input logic [1:0] beat);
        return {beat, 2'b00};
    endfunction

endpackage

// File: rtl/mem_bus_line_reg.sv
// 128-bit line latch with one write enable per 32-bit beat.
module mem_bus_line_reg
    import mem_bus_pkg::*;
#(
    parameter int WORD_W = MEM_WORD_W,
    parameter int BEATS  = MEM_BEATS
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [BEATS-1:0]          we,
    input  logic [BEATS*WORD_W-1:0]   din,
    output logic [BEATS*WORD_W-1:0]   q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= '0;
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                if (we[i]) q[i*WORD_W +: WORD_W] <= din[i*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Serialises cache line fills/writebacks into four word beats on an ack-handshaked memory port.
// Optional write posting: define MEM_BUS_WPOST_EN to complete writebacks at acceptance.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = MEM_LINE_W,
    parameter int WORD_W = MEM_WORD_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              BUS_EN,
    input  logic              BUS_WR,
    input  logic [ADDR_W-1:0] BUS_ADDR,
    input  logic [LINE_W-1:0] BUS_WRITE,
    output logic              BUS_R,
    output logic [LINE_W-1:0] BUS_READ,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack
);

`ifdef MEM_BUS_WPOST_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    state_t                 state, state_nx;
    logic [1:0]             beat;
    logic [ADDR_W-5:0]      line_addr;
    logic                   wr;
    logic [LINE_W-1:0]      wline;
    logic                   accept, beat_done, last_beat;
    logic [MEM_BEATS-1:0]   beat_sel;
    logic                   unused_addr;

    assign accept      = (state == IDLE) && BUS_EN;
    assign beat_done   = (state == BEAT) && mem_ack;
    assign last_beat   = beat_done && (beat == 2'd3);
    assign beat_sel    = MEM_BEATS'(1) << beat;
    assign unused_addr = ^BUS_ADDR[3:0];

    mem_bus_line_reg #(.WORD_W(WORD_W), .BEATS(MEM_BEATS)) u_wb_line (
        .clk (clk),
        .clr (clr),
        .we  ({MEM_BEATS{accept}}),
        .din (BUS_WRITE),
        .q   (wline)
    );

    // Fill data lands one beat at a time and only on read acks.
    mem_bus_line_reg #(.WORD_W(WORD_W), .BEATS(MEM_BEATS)) u_rd_line (
        .clk (clk),
        .clr (clr),
        .we  ((beat_done && !wr) ? beat_sel : '0),
        .din ({MEM_BEATS{mem_rdata}}),
        .q   (BUS_READ)
    );

    assign mem_addr  = {line_addr, beat_offset(beat)};
    assign mem_wdata = wline[beat*WORD_W +: WORD_W];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (BUS_EN) state_nx = BEAT;
            BEAT: if (last_beat) state_nx = (POSTED && wr) ? GAP : RESP;
            RESP: state_nx = GAP;
            GAP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            beat      <= 2'd0;
            line_addr <= '0;
            wr        <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            BUS_R     <= 1'b0;
        end else begin
            // A posted writeback completes toward the cache as soon as it is latched.
            BUS_R <= (state == BEAT && state_nx == RESP) || (POSTED && accept && BUS_WR);
            if (accept) begin
                wr        <= BUS_WR;
                line_addr <= BUS_ADDR[ADDR_W-1:4];
                beat      <= 2'd0;
                mem_req   <= 1'b1;
                mem_we    <= BUS_WR;
            end else if (beat_done) begin
                if (beat == 2'd3) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end else begin
                    beat <= beat + 2'd1;
                end
            end
        end
    end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Line-fill and writeback controller that sits directly downstream of the data cache. It services the cache's 128-bit line requests (`BUS_EN`/`BUS_WR`/`BUS_ADDR`/`BUS_WRITE`) and returns `BUS_R`/`BUS_READ`. It serialises each line into four 32-bit beats on a word-wide, ack-handshaked main-memory port.

## Interface
Parameters:
- `ADDR_W`, 16: byte address width; matches the cache `BUS_ADDR`.
- `LINE_W`, 128: cache line width.
- `WORD_W`, 32: memory beat width. `LINE_W/WORD_W` must equal 4.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock; all flops rise-edge.
  - `clr`  in  1  asynchronous active-low reset.
- Cache side:
  - `BUS_EN`  in  1  request, held by the cache until `BUS_R`.
  - `BUS_WR`  in  1  1 = writeback, 0 = line fill; qualified by `BUS_EN`.
  - `BUS_ADDR`  in  16  line address; bits [3:0] ignored.
  - `BUS_WRITE`  in  128  writeback data.
  - `BUS_R`  out  1  one-cycle completion pulse.
  - `BUS_READ`  out  128  fill data; valid in the `BUS_R` cycle and held until the next fill completes.
- Memory side:
  - `mem_req`  out  1  beat request.
  - `mem_we`  out  1  beat is a write.
  - `mem_addr`  out  16  beat byte address.
  - `mem_wdata`  out  32  beat write data.
  - `mem_rdata`  in  32  beat read data; valid with `mem_ack`.
  - `mem_ack`  in  1  beat complete.

## Operation
- States and transitions:
  - IDLE: sample `BUS_EN`. If it is 1, latch `BUS_WR`, `BUS_ADDR[15:4]` and `BUS_WRITE`, clear `beat` to 0, go to BEAT.
  - BEAT: assert `mem_req`.
    - Drive `mem_addr = {addr[15:4], beat[1:0], 2'b00}` and `mem_we = wr`.
    - Drive `mem_wdata = line[32*beat+31 : 32*beat]`.
    - On `mem_ack` with a read: capture `mem_rdata` into `BUS_READ[32*beat+31 : 32*beat]`.
    - On `mem_ack` with `beat < 3`: `beat <= beat+1`.
    - On `mem_ack` with `beat == 3`: go to RESP.
  - RESP: `BUS_R = 1` for exactly one cycle, then GAP.
  - GAP: one cycle in which `BUS_EN` is ignored, giving the cache time to drop its request; then IDLE.
- Beat handling:
  - Beat order is always 0..3; the address never carries out of the line.
  - `mem_ack` while `mem_req = 0` is ignored.
  - Wait states are unbounded; `mem_req` and the address are held stable until `mem_ack`.
- `BUS_READ` is not updated by writebacks.
- `BUS_ADDR`/`BUS_WRITE`/`BUS_WR` changes after acceptance are ignored; the latched copy is used.
- Reset (`clr = 0`, any time, including mid-burst):
  - State goes to IDLE, `beat` to 0.
  - `mem_req`, `mem_we`, `BUS_R` go to 0.
  - `mem_addr`, `mem_wdata`, `BUS_READ` go to 0.
  - An in-flight memory beat is abandoned.
- All outputs are registered, except `mem_addr` and `mem_wdata`, which may be muxed from registered `beat` and the line latch.

## Timing
- A request is accepted at the edge ending cycle 0 with `BUS_EN = 1` in IDLE.
- With zero-wait memory (`mem_ack` every cycle):
  - `mem_req` is high in cycles 1–4.
  - `BUS_R` is high in cycle 5.
  - GAP is cycle 6.
  - The earliest next acceptance is the edge ending cycle 7.
- Each wait cycle (`mem_req = 1`, `mem_ack = 0`) adds one cycle.
- Fill and writeback latency are identical without `MEM_BUS_WPOST_EN`.

## Configuration
- `MEM_BUS_WPOST_EN` defined (write posting):
  - A writeback accepted in IDLE pulses `BUS_R` in cycle 1.
  - The four beats drain in the background (cycles 1–4 at zero wait).
  - A new request is not accepted until the drain completes and GAP has passed; the earliest next acceptance is the edge ending cycle 6 at zero wait.
  - Reset discards an undrained line.
- Undefined: writebacks complete only after the beat-3 ack, as described above.
- Fills behave identically in both builds.

## Structure
- `mem_bus_pkg` holds:
  - the state enum (IDLE, BEAT, RESP, GAP);
  - `MEM_BEATS = 4`, `MEM_WORD_W = 32`, `MEM_LINE_W = 128`;
  - the beat-to-address helper function.
- One sub-module, `mem_bus_line_reg`: the 128-bit line latch with a per-beat 32-bit write enable. It is used for both the writeback latch and `BUS_READ` assembly.

## Test plan
- Fill, zero-wait memory, `BUS_ADDR = 16'h010B`, memory words `32'hA0..A3`:
  - `mem_addr` = `0100`, `0104`, `0108`, `010C` in cycles 1–4.
  - `BUS_R` in cycle 5.
  - `BUS_READ = 128'h000000A3_000000A2_000000A1_000000A0`.
- Writeback, `BUS_WRITE = 128'h33333333_22222222_11111111_00000000`, `BUS_ADDR = 16'h0200`: `mem_we = 1` and `mem_wdata` = `00000000`, `11111111`, `22222222`, `33333333` at addresses `0200`..`020C`.
- Two wait states on beat 2: `mem_addr` held at `0108` for 3 cycles; `BUS_R` in cycle 7.
- `BUS_EN` held high through `BUS_R`: no second burst starts before the edge ending cycle 7; the second request's beats begin in cycle 8.
- Reset in cycle 3 of a fill: all outputs are 0 next cycle; a fresh request afterwards completes with correct data.
- Writeback with `MEM_BUS_WPOST_EN`: `BUS_R` in cycle 1; a fill held from cycle 2 is accepted at the edge ending cycle 6 (zero wait), and its beats begin in cycle 7.
